// File: rtl/brg_cgra_pkg.sv
// Shared types for the CGRA SDR reset sequencer: state enum,
// output bundle, per-state output decode and sizing helpers.
package brg_cgra_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_TOKEN  = 3'd1,
    ST_UP_REL = 3'd2,
    ST_DN_REL = 3'd3,
    ST_DS_REL = 3'd4,
    ST_DONE   = 3'd5
  } brg_cgra_rst_state_e;

  typedef struct packed {
    logic core;
    logic up;
    logic dn;
    logic ds;
    logic tok;
    logic done;
  } brg_cgra_rst_out_t;

  localparam brg_cgra_rst_out_t RST_OUT_HOLD =
    '{core: 1'b1, up: 1'b1, dn: 1'b1,
      ds: 1'b1, tok: 1'b0, done: 1'b0};

  // Illegal encodings fall to the HOLD outputs so every reset
  // stays asserted until the FSM recovers on the next edge.
  function automatic brg_cgra_rst_out_t rst_out_decode(
    input brg_cgra_rst_state_e st
  );
    brg_cgra_rst_out_t o;
    o = RST_OUT_HOLD;
    case (st)
      ST_TOKEN:  o.tok = 1'b1;
      ST_UP_REL: o.up  = 1'b0;
      ST_DN_REL: begin
        o.up = 1'b0;
        o.dn = 1'b0;
      end
      ST_DS_REL: begin
        o.up = 1'b0;
        o.dn = 1'b0;
        o.ds = 1'b0;
      end
      ST_DONE:   o = '{core: 1'b0, up: 1'b0, dn: 1'b0,
                       ds: 1'b0, tok: 1'b0, done: 1'b1};
      default:   o = RST_OUT_HOLD;
    endcase
    return o;
  endfunction

  function automatic int safe_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/brg_cgra_reset_seq_timer.sv
// Clear/increment state timer with a programmable terminal compare.
// Ports: i_clk, i_rst (async high), i_clr, i_term -> o_tc.
module brg_cgra_reset_seq_timer #(
  parameter int width_p = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic [width_p-1:0] i_term,
  output logic               o_tc
);

  logic [width_p-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/brg_cgra_sdr_reset_seq.sv
// Timed reset bring-up for the SDR link column and CGRA half pod.
// Ports: clk_i, reset_i, restart_i -> link/core resets, done_o, state_o.
module brg_cgra_sdr_reset_seq
  import brg_cgra_pkg::*;
#(
  parameter int hold_cycles_p        = 16,
  parameter int token_pulse_cycles_p = 4,
  parameter int step_cycles_p        = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       restart_i,
  output logic       core_reset_o,
  output logic       async_uplink_reset_o,
  output logic       async_downlink_reset_o,
  output logic       async_downstream_reset_o,
  output logic       async_token_reset_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  localparam int cnt_width_lp = safe_clog2(
    max3(hold_cycles_p, token_pulse_cycles_p, step_cycles_p) + 1);

  localparam logic [cnt_width_lp-1:0] HOLD_TERM_LP =
    cnt_width_lp'(hold_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] TOK_TERM_LP =
    cnt_width_lp'(token_pulse_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] STEP_TERM_LP =
    cnt_width_lp'(step_cycles_p - 1);

  brg_cgra_rst_state_e       r_state;
  brg_cgra_rst_state_e       w_next;
  brg_cgra_rst_out_t         r_out;
  logic [cnt_width_lp-1:0]   w_term;
  logic                      w_tc;
  logic                      w_clr;

  always_comb begin
    w_term = STEP_TERM_LP;
    case (r_state)
      ST_HOLD:  w_term = HOLD_TERM_LP;
      ST_TOKEN: w_term = TOK_TERM_LP;
      default:  w_term = STEP_TERM_LP;
    endcase
  end

  // Restart overrides any terminal count; illegal codes go to HOLD.
  always_comb begin
    w_next = r_state;
    if (restart_i) begin
      w_next = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD:   w_next = w_tc ? ST_TOKEN  : ST_HOLD;
        ST_TOKEN:  w_next = w_tc ? ST_UP_REL : ST_TOKEN;
        ST_UP_REL: w_next = w_tc ? ST_DN_REL : ST_UP_REL;
        ST_DN_REL: w_next = w_tc ? ST_DS_REL : ST_DN_REL;
        ST_DS_REL: w_next = w_tc ? ST_DONE   : ST_DS_REL;
        ST_DONE:   w_next = ST_DONE;
        default:   w_next = ST_HOLD;
      endcase
    end
  end

  // Counter clears on every state entry, on restart, and parks at
  // zero in DONE so it never runs past the terminal value.
  assign w_clr = restart_i
              | (w_next != r_state)
              | (r_state == ST_DONE);

  brg_cgra_reset_seq_timer #(
    .width_p (cnt_width_lp)
  ) u_timer (
    .i_clk  (clk_i),
    .i_rst  (reset_i),
    .i_clr  (w_clr),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  // Outputs are registered from the next state so they change only
  // on clock edges and carry no decode glitches.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_HOLD;
      r_out   <= RST_OUT_HOLD;
    end else begin
      r_state <= w_next;
      r_out   <= rst_out_decode(w_next);
    end
  end

  assign core_reset_o             = r_out.core;
  assign async_uplink_reset_o     = r_out.up;
  assign async_downlink_reset_o   = r_out.dn;
  assign async_downstream_reset_o = r_out.ds;
  assign async_token_reset_o      = r_out.tok;
  assign done_o                   = r_out.done;
  assign state_o                  = r_state;

endmodule
